// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, TX FSM states and STATUS bit positions
// shared by the Uart MMIO controller and its bench.
package uart_ctrl_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_RXDATA = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;
    localparam logic [3:0] UART_BAUD   = 4'hC;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT_B,
        TX_WAIT_D
    } tx_state_t;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_RX_IE    = 6;
    localparam int ST_TX_IE    = 7;

    // Last WAIT_B cycle before giving up on busy (4 cycles total).
    localparam logic [1:0] WAIT_B_LAST = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers.
// Pushes to a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped sequencer for the Uart byte engine,
// with TX/RX FIFOs, sticky error flags, irq and baud configuration.
module uart_mmio_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 16,
    parameter logic [31:0] CLK_FREQ     = 32'd27_000_000,
    parameter logic [31:0] BAUD_DEFAULT = 32'd115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        irq,
    output logic        uart_we,
    output logic [7:0]  uart_data,
    output logic [31:0] uart_baud,
    output logic [31:0] uart_clk_freq,
    input  logic        uart_busy,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [1:0]  wait_cnt;
    logic [7:0]  data_q;
    logic [31:0] baud_reg;
    logic        tx_ovf;
    logic        rx_ovr;
    logic        tx_ie;
    logic        rx_ie;
    logic        rx_valid_q;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  tx_head;
    logic [7:0]  rx_head;
    logic [TXW:0] tx_count;
    logic [RXW:0] rx_count;
    logic [3:0]  sel;
    logic        wr_tx;
    logic        wr_st;
    logic        wr_baud;
    logic        rd_rx;
    logic        rx_rise;
    logic        tx_pop;
    logic [31:0] status;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign sel     = {bus_addr[3:2], 2'b00};
    assign wr_tx   = bus_we && (sel == UART_TXDATA);
    assign wr_st   = bus_we && (sel == UART_STATUS);
    assign wr_baud = bus_we && (sel == UART_BAUD);
    assign rd_rx   = bus_re && (sel == UART_RXDATA);
    assign rx_rise = uart_rx_valid && !rx_valid_q;

    assign unused_bits = ^{bus_addr[1:0], tx_count, rx_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .din   (bus_wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_rise),
        .din   (uart_rx_data),
        .pop   (rd_rx),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign status = {24'b0, tx_ie, rx_ie, rx_ovr, tx_ovf,
                     rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        rd_word = '0;
        case (sel)
            UART_RXDATA: rd_word = rx_empty ? 32'd0 : {24'b0, rx_head};
            UART_STATUS: rd_word = status;
            UART_BAUD:   rd_word = baud_reg;
            default:     rd_word = '0;
        endcase
    end

    assign irq = (rx_ie && !rx_empty) || (tx_ie && tx_empty);
    assign uart_clk_freq = CLK_FREQ;

    // Bus side: registered reads, sticky flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            tx_ovf     <= 1'b0;
            rx_ovr     <= 1'b0;
            tx_ie      <= 1'b0;
            rx_ie      <= 1'b0;
            baud_reg   <= BAUD_DEFAULT;
            uart_baud  <= BAUD_DEFAULT;
            rx_valid_q <= 1'b0;
        end else begin
            bus_rvalid <= bus_re;
            if (bus_re) bus_rdata <= rd_word;
            if (wr_tx && tx_full) begin
                tx_ovf <= 1'b1;
            end else if (wr_st && bus_wdata[ST_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
            if (rx_rise && rx_full) begin
                rx_ovr <= 1'b1;
            end else if (wr_st && bus_wdata[ST_RX_OVR]) begin
                rx_ovr <= 1'b0;
            end
            if (wr_st) begin
                tx_ie <= bus_wdata[ST_TX_IE];
                rx_ie <= bus_wdata[ST_RX_IE];
            end
            if (wr_baud) baud_reg <= bus_wdata;
            if (state == TX_IDLE) uart_baud <= baud_reg;
            rx_valid_q <= uart_rx_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            wait_cnt <= '0;
            data_q   <= '0;
        end else begin
            state <= state_next;
            if (state == TX_WAIT_B) wait_cnt <= wait_cnt + 1'b1;
            else                    wait_cnt <= '0;
            if (state == TX_ISSUE) data_q <= tx_head;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TX_IDLE: begin
                if (!tx_empty && !uart_busy) state_next = TX_ISSUE;
            end
            TX_ISSUE: begin
                state_next = TX_WAIT_B;
            end
            TX_WAIT_B: begin
                if (uart_busy)                   state_next = TX_WAIT_D;
                else if (wait_cnt == WAIT_B_LAST) state_next = TX_IDLE;
            end
            TX_WAIT_D: begin
                if (!uart_busy) state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_we   = 1'b0;
        uart_data = data_q;
        tx_pop    = 1'b0;
        if (state == TX_ISSUE) begin
            uart_we   = 1'b1;
            uart_data = tx_head;
            tx_pop    = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: scoreboard bench with a queue-based reference model,
// a behavioural Uart busy model and randomized bus/RX traffic.
module tb_uart_mmio_ctrl;
    import uart_ctrl_pkg::*;

    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam logic [31:0] BAUD_DEF = 32'd115200;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        irq;
    logic        uart_we;
    logic [7:0]  uart_data;
    logic [31:0] uart_baud;
    logic [31:0] uart_clk_freq;
    logic        uart_busy;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;

    uart_mmio_ctrl #(
        .TX_DEPTH     (TXD),
        .RX_DEPTH     (RXD),
        .CLK_FREQ     (32'd27_000_000),
        .BAUD_DEFAULT (BAUD_DEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .irq           (irq),
        .uart_we       (uart_we),
        .uart_data     (uart_data),
        .uart_baud     (uart_baud),
        .uart_clk_freq (uart_clk_freq),
        .uart_busy     (uart_busy),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        string       nm;
    } rd_t;

    int tests = 0;
    int fails = 0;

    rd_t        exp_rd[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];
    bit         m_tx_ovf, m_rx_ovr, m_tx_ie, m_rx_ie;
    int         tx_pushed = 0;
    int         tx_issued = 0;

    // Uart model: busy rises the cycle after write_enable, sometimes never.
    bit hold_busy = 0;
    bit long_busy = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (uart_we) begin
            if (long_busy)                     busy_cnt <= 60;
            else if ($urandom_range(0, 3) == 0) busy_cnt <= 0;
            else                               busy_cnt <= $urandom_range(2, 8);
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = hold_busy || (busy_cnt > 0);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm, input int act, input int req);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    // TX monitor: each Uart write must match the next queued byte.
    bit prev_we = 0;
    always @(negedge clk) begin
        if (uart_we) begin
            chk("tx_gap", {31'b0, prev_we}, 32'd0);
            chk("tx_busy_at_we", {31'b0, uart_busy}, 32'd0);
            if (exp_tx.size() == 0) fail_now("tx_unexpected_bytes", 1, 0);
            else chk("tx_data", {24'b0, uart_data}, {24'b0, exp_tx.pop_front()});
            tx_issued++;
        end
        prev_we = uart_we;
    end

    // Read monitor: each rvalid pulse pops one expected response.
    rd_t rd_e;
    always @(negedge clk) begin
        if (bus_rvalid) begin
            if (exp_rd.size() == 0) fail_now("rd_unexpected", 1, 0);
            else begin
                rd_e = exp_rd.pop_front();
                chk(rd_e.nm, bus_rdata & rd_e.m, rd_e.d & rd_e.m);
            end
        end
    end

    function automatic logic [31:0] m_status(input bit txe, input bit txf);
        bit rxf = (rx_q.size() == RXD);
        bit rxe = (rx_q.size() == 0);
        return {24'b0, m_tx_ie, m_rx_ie, m_rx_ovr, m_tx_ovf,
                rxf, rxe, txf, txe};
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] e,
                            input logic [31:0] m, input string nm);
        exp_rd.push_back('{e, m, nm});
        @(negedge clk);
        bus_addr = a;
        bus_re   = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
    endtask

    task automatic st_write(input logic [31:0] d);
        m_tx_ie = d[ST_TX_IE];
        m_rx_ie = d[ST_RX_IE];
        if (d[ST_TX_OVF]) m_tx_ovf = 0;
        if (d[ST_RX_OVR]) m_rx_ovr = 0;
        bus_write(UART_STATUS, d);
    endtask

    task automatic tx_write(input logic [7:0] b, input bit stored);
        if (stored) begin
            exp_tx.push_back(b);
            tx_pushed++;
        end else m_tx_ovf = 1;
        bus_write(UART_TXDATA, {24'hABCDEF, b});
    endtask

    task automatic rx_read(input string nm);
        logic [31:0] e;
        e = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'd0;
        bus_read(UART_RXDATA, e, 32'hFFFF_FFFF, nm);
    endtask

    task automatic rx_byte(input logic [7:0] d, input int hold);
        if (rx_q.size() < RXD) rx_q.push_back(d);
        else m_rx_ovr = 1;
        @(negedge clk);
        uart_rx_valid = 1'b1;
        uart_rx_data  = d;
        repeat (hold) @(negedge clk);
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_tx.size() != 0 || uart_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now(nm, exp_tx.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] w;
        int          r;
        int          n;

        rst = 1'b1;
        bus_addr = '0;
        bus_wdata = '0;
        bus_we = 1'b0;
        bus_re = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_rvalid", {31'b0, bus_rvalid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_uart_we", {31'b0, uart_we}, 32'd0);
        chk("rst_uart_data", {24'b0, uart_data}, 32'd0);
        chk("rst_baud", uart_baud, BAUD_DEF);
        chk("clk_freq", uart_clk_freq, 32'd27_000_000);
        rst = 1'b0;
        @(negedge clk);
        bus_read(UART_STATUS, m_status(1, 0), '1, "rst_status");

        // Three bytes in order, each after the previous frame.
        tx_write(8'h41, 1);
        tx_write(8'h42, 1);
        tx_write(8'h43, 1);
        wait_drain("t1_drain");
        bus_read(UART_STATUS, m_status(1, 0), '1, "t1_status");

        // TX overflow while the Uart stays busy.
        hold_busy = 1;
        for (int i = 0; i < 17; i++) tx_write(8'(8'h60 + i), i < TXD);
        repeat (3) @(negedge clk);
        chk("t2_no_issue", {31'b0, uart_we}, 32'd0);
        bus_read(UART_STATUS, m_status(0, 1), '1, "t2_status_full");
        st_write(32'h10);
        bus_read(UART_STATUS, m_status(0, 1), '1, "t2_status_clr");
        hold_busy = 0;
        wait_drain("t2_drain");
        st_write(32'h80);
        chk("t2_irq_tx_ie", {31'b0, irq}, 32'd1);
        st_write(32'h00);
        chk("t2_irq_off", {31'b0, irq}, 32'd0);

        // Long rx_valid level yields a single byte.
        rx_byte(8'h5A, 200);
        rx_read("t3_rx_5a");
        bus_read(UART_STATUS, m_status(1, 0), '1, "t3_status");
        rx_read("t3_rx_empty");

        // RX overflow and irq enable.
        for (int i = 0; i < 17; i++) rx_byte(8'($urandom), 1 + (i % 3));
        chk("t4_irq_disabled", {31'b0, irq}, 32'd0);
        st_write(32'h40);
        chk("t4_irq_rx_ie", {31'b0, irq}, 32'd1);
        bus_read(UART_STATUS, m_status(1, 0), '1, "t4_status");
        st_write(32'h60);

        // Pop and rising rx_valid together on a full RX FIFO.
        e = {24'b0, rx_q.pop_front()};
        m_rx_ovr = 1;
        exp_rd.push_back('{e, 32'hFFFF_FFFF, "t5_pop"});
        @(negedge clk);
        bus_addr = UART_RXDATA;
        bus_re = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'hEE;
        @(negedge clk);
        bus_re = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < RXD - 1; i++) rx_read("t5_drain_rx");
        bus_read(UART_STATUS, m_status(1, 0), '1, "t5_status");
        chk("t5_irq_empty", {31'b0, irq}, 32'd0);
        st_write(32'h20);

        // Randomized traffic; tx_ie stays 0 so irq is predictable.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                if (tx_pushed - tx_issued < 12) tx_write(8'($urandom), 1);
            end else if (r <= 5) begin
                rx_byte(8'($urandom), $urandom_range(1, 6));
            end else if (r <= 7) begin
                rx_read("rnd_rxdata");
            end else if (r == 8) begin
                bus_read(UART_STATUS, m_status(0, 0), 32'hFFFF_FFFC,
                         "rnd_status");
            end else begin
                w = $urandom & 32'h60;
                st_write(w);
                chk("rnd_irq", {31'b0, irq},
                    {31'b0, m_rx_ie && rx_q.size() != 0});
            end
        end
        wait_drain("rnd_drain");
        while (rx_q.size() != 0) rx_read("rnd_rx_flush");
        st_write(32'h30);

        // BAUD register, then reset in the middle of a frame.
        bus_write(UART_BAUD, 32'd9600);
        repeat (4) @(negedge clk);
        chk("t6_baud_applied", uart_baud, 32'd9600);
        bus_read(UART_BAUD, 32'd9600, '1, "t6_baud_read");
        long_busy = 1;
        tx_write(8'hC1, 1);
        for (int i = 0; i < 3; i++) tx_write(8'(8'hC2 + i), 0);
        m_tx_ovf = 0;
        n = 0;
        while ((exp_tx.size() != 0 || !uart_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("t6_wait_busy", n, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        long_busy = 0;
        rx_q.delete();
        m_tx_ovf = 0;
        m_rx_ovr = 0;
        m_tx_ie = 0;
        m_rx_ie = 0;
        tx_pushed = tx_issued;
        chk("t6_uart_we", {31'b0, uart_we}, 32'd0);
        chk("t6_baud_default", uart_baud, BAUD_DEF);
        bus_read(UART_STATUS, m_status(1, 0), '1, "t6_status");
        repeat (30) @(negedge clk);
        bus_read(UART_BAUD, BAUD_DEF, '1, "t6_baud_reg");

        repeat (5) @(negedge clk);
        if (exp_rd.size() != 0) fail_now("rd_pending", exp_rd.size(), 0);
        if (exp_tx.size() != 0) fail_now("tx_pending", exp_tx.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
